// File: rtl/float2fix_pkg.sv
// Shared constants for the double -> sign-magnitude fixed-point converter:
// IEEE-754 double field geometry, result type codes and FSM state encoding.
package float2fix_pkg;

  localparam int DBL_EXP_W = 11;
  localparam int DBL_MAN_W = 52;
  localparam int DBL_BIAS  = 1023;

  localparam logic [2:0] OT_NORMAL = 3'd0;
  localparam logic [2:0] OT_NAN    = 3'd1;
  localparam logic [2:0] OT_PINF   = 3'd2;
  localparam logic [2:0] OT_NINF   = 3'd3;
  localparam logic [2:0] OT_OVF    = 3'd4;
  localparam logic [2:0] OT_UNDER  = 3'd5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

endpackage

// File: rtl/f2f_classify.sv
// Combinational split of an IEEE-754 double into sign/exponent/significand
// plus NaN, infinity, zero and subnormal classification.
module f2f_classify
  import float2fix_pkg::*;
(
  input  logic [63:0]          data_i,
  output logic                 sign_o,
  output logic [DBL_EXP_W-1:0] exp_o,
  output logic [DBL_MAN_W:0]   sig_o,
  output logic                 is_nan_o,
  output logic                 is_inf_o,
  output logic                 is_zero_o,
  output logic                 is_sub_o
);

  logic exp_max, exp_min, man_nz;

  assign sign_o  = data_i[63];
  assign exp_o   = data_i[62:52];
  assign sig_o   = {1'b1, data_i[51:0]};

  assign exp_max = (data_i[62:52] == {DBL_EXP_W{1'b1}});
  assign exp_min = (data_i[62:52] == {DBL_EXP_W{1'b0}});
  assign man_nz  = |data_i[51:0];

  assign is_nan_o  = exp_max &  man_nz;
  assign is_inf_o  = exp_max & ~man_nz;
  assign is_zero_o = exp_min & ~man_nz;
  assign is_sub_o  = exp_min &  man_nz;

endmodule

// File: rtl/float2fix_conv.sv
// IEEE-754 double -> sign-magnitude INT_W.FRAC_W converter, 4-cycle latency,
// valid/ready on both sides. Define F2F_ROUND_NEAREST_EN for round-half-to-even.
module float2fix_conv
  import float2fix_pkg::*;
#(
  parameter int INT_W  = 14,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [INT_W-1:0]  integer_part,
  output logic [FRAC_W-1:0] fraction_part,
  output logic [2:0]        output_type
);

  localparam int N  = INT_W + FRAC_W;
  localparam int SW = 64 + 55;
  // Fixed-point LSB lands on bit GB+1 of the shifter; GB is the guard bit.
  localparam int GB = 54;

  function automatic logic [N-1:0] saturate(input logic en);
    return en ? {N{1'b1}} : {N{1'b0}};
  endfunction

  function automatic logic [N:0] rne(input logic [N-1:0] q, input logic g, input logic st);
    return {1'b0, q} + {{N{1'b0}}, g & (st | q[0])};
  endfunction

  logic [2:0]  state_q, state_d;
  logic [63:0] op_q;

  logic                 cls_sign, cls_nan, cls_inf, cls_zero, cls_sub;
  logic [DBL_EXP_W-1:0] cls_exp;
  logic [DBL_MAN_W:0]   cls_sig;

  logic signed [12:0] exp_s, sh_s;
  logic               dec_fix_d, dec_sat_d;
  logic [2:0]         dec_type_d;
  logic [6:0]         dec_sh_d;
  logic               dec_fix_q, dec_sat_q, dec_sign_q;
  logic [2:0]         dec_type_q;
  logic [6:0]         dec_sh_q;
  logic [DBL_MAN_W:0] dec_sig_q;

  logic [SW-1:0] shf_q;
  logic [N-1:0]  q_lo;
  logic [N:0]    rnd;
  logic          hi_nz;
  logic [N-1:0]  mag_d, mag_q;
  logic [2:0]    type_d, type_q;
  logic          out_valid_q, sign_q;

  f2f_classify u_classify (
    .data_i    (op_q),
    .sign_o    (cls_sign),
    .exp_o     (cls_exp),
    .sig_o     (cls_sig),
    .is_nan_o  (cls_nan),
    .is_inf_o  (cls_inf),
    .is_zero_o (cls_zero),
    .is_sub_o  (cls_sub)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_SHIFT;
      ST_SHIFT:  state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_HOLD;
      ST_HOLD:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // DECODE: unbiased exponent and shift that puts the fixed-point LSB at GB+1
  always_comb begin
    exp_s      = $signed({2'b00, cls_exp}) - 13'(DBL_BIAS);
    sh_s       = exp_s + 13'(FRAC_W + 3);
    dec_fix_d  = 1'b1;
    dec_sat_d  = 1'b0;
    dec_type_d = OT_NORMAL;
    dec_sh_d   = '0;
    if (cls_nan) begin
      dec_type_d = OT_NAN;
    end else if (cls_inf) begin
      dec_type_d = cls_sign ? OT_NINF : OT_PINF;
      dec_sat_d  = 1'b1;
    end else if (cls_zero) begin
      dec_type_d = OT_NORMAL;
    end else if (cls_sub) begin
      dec_type_d = OT_UNDER;
    end else if (exp_s >= 13'(INT_W)) begin
      dec_type_d = OT_OVF;
      dec_sat_d  = 1'b1;
    end else if (sh_s <= 13'sd0) begin
      // Everything, guard bit included, falls below the LSB.
      dec_type_d = OT_UNDER;
    end else begin
      dec_fix_d = 1'b0;
      dec_sh_d  = 7'(sh_s);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) op_q <= in_data;
    if (state_q == ST_DECODE) begin
      dec_fix_q  <= dec_fix_d;
      dec_sat_q  <= dec_sat_d;
      dec_type_q <= dec_type_d;
      dec_sh_q   <= dec_sh_d;
      dec_sign_q <= cls_sign;
      dec_sig_q  <= cls_sig;
    end
    // SHIFT: full-width alignment, nothing truncated before ROUND
    if (state_q == ST_SHIFT) shf_q <= SW'(dec_sig_q) << dec_sh_q;
  end

  // ROUND: take the N result bits, optionally round, then classify the result
  always_comb begin
    q_lo  = shf_q[GB+1 +: N];
    hi_nz = |(shf_q >> (GB + 1 + N));
`ifdef F2F_ROUND_NEAREST_EN
    rnd = rne(q_lo, shf_q[GB], |shf_q[GB-1:0]);
`else
    rnd = {1'b0, q_lo};
`endif
    mag_d  = saturate(dec_sat_q);
    type_d = dec_type_q;
    if (!dec_fix_q) begin
      if (rnd[N] || hi_nz) begin
        mag_d  = saturate(1'b1);
        type_d = OT_OVF;
      end else if (rnd[N-1:0] == '0) begin
        mag_d  = '0;
        type_d = OT_UNDER;
      end else begin
        mag_d  = rnd[N-1:0];
        type_d = OT_NORMAL;
      end
    end
  end

`ifndef F2F_ROUND_NEAREST_EN
  logic unused_discard;
  assign unused_discard = ^shf_q[GB:0];
`endif

  // HOLD: result registers load only on ROUND -> HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      type_q      <= OT_NORMAL;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ROUND) begin
        out_valid_q <= 1'b1;
        sign_q      <= dec_sign_q;
        mag_q       <= mag_d;
        type_q      <= type_d;
      end else if (state_q == ST_HOLD && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = out_valid_q;
  assign sign          = sign_q;
  assign integer_part  = mag_q[N-1:FRAC_W];
  assign fraction_part = mag_q[FRAC_W-1:0];
  assign output_type   = type_q;

endmodule

// File: tb/tb_float2fix_conv.sv
// Scoreboard bench for float2fix_conv (14.4): a real-arithmetic model predicts each
// result at issue time; a negedge monitor pops and compares on every output handshake.
module tb_float2fix_conv;

  localparam int INT_W  = 14;
  localparam int FRAC_W = 4;
  localparam int N      = INT_W + FRAC_W;

  typedef struct packed {
    logic              s;
    logic [INT_W-1:0]  ip;
    logic [FRAC_W-1:0] fp;
    logic [2:0]        t;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [63:0]       in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              sign;
  logic [INT_W-1:0]  integer_part;
  logic [FRAC_W-1:0] fraction_part;
  logic [2:0]        output_type;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic bp_en = 1'b0;
  logic ready_force = 1'b1;

  float2fix_conv #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sign          (sign),
    .integer_part  (integer_part),
    .fraction_part (fraction_part),
    .output_type   (output_type)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: exact value via $bitstoreal, scaled by 2^FRAC_W, floor / half-even.
  function automatic res_t model(input logic [63:0] d);
    res_t   r;
    logic [10:0] ex;
    real    a, x, fl;
    longint q;
`ifdef F2F_ROUND_NEAREST_EN
    real    fr;
`endif
    r.s = d[63]; r.ip = '0; r.fp = '0; r.t = 3'd0;
    ex  = d[62:52];
    if (ex == 11'h7FF) begin
      if (d[51:0] != 52'd0) r.t = 3'd1;
      else begin
        r.t = d[63] ? 3'd3 : 3'd2;
        {r.ip, r.fp} = '1;
      end
      return r;
    end
    if (ex == 11'd0) begin
      r.t = (d[51:0] != 52'd0) ? 3'd5 : 3'd0;
      return r;
    end
    a = $bitstoreal({1'b0, d[62:0]});
    if (a >= real'(longint'(1) << INT_W)) begin
      r.t = 3'd4;
      {r.ip, r.fp} = '1;
      return r;
    end
    x  = a * real'(longint'(1) << FRAC_W);
    fl = $floor(x);
    q  = longint'(fl);
`ifdef F2F_ROUND_NEAREST_EN
    fr = x - fl;
    if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
`endif
    if (q >= (longint'(1) << N)) begin
      r.t = 3'd4;
      {r.ip, r.fp} = '1;
    end else if (q == 0) begin
      r.t = 3'd5;
    end else begin
      {r.ip, r.fp} = q[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic [63:0] d;
    int k;
    k = $urandom_range(0, 19);
    d = {$urandom, $urandom};
    if (k == 0)      d[62:52] = 11'h7FF;
    else if (k == 1) d[62:52] = 11'd0;
    else begin
      d[62:52] = 11'(1023 - 72 + $urandom_range(0, 90));
      if (k == 2) d[51:0] = '0;
      if (k == 3) d[40:0] = '0;
    end
    return d;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: actual type=%0d required no result", output_type);
      end else begin
        e = exp_q.pop_front();
        chk("sign", sign, e.s);
        chk("integer_part", integer_part, e.ip);
        chk("fraction_part", fraction_part, e.fp);
        chk("output_type", output_type, e.t);
      end
    end
  end

  task automatic send(input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(model(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (out_valid) return;
    end
    total++;
    bad++;
    $display("FAIL out_valid_timeout: actual=0 required=1");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  logic [63:0] directed [12] = '{
    64'h3FF8000000000000, 64'hC006000000000000, 64'h7FF0000000000000,
    64'h7FF8000000000000, 64'h40D0000000000000, 64'h3F00000000000000,
    64'h3FB8000000000000, 64'hFFF0000000000000, 64'h0000000000000000,
    64'h8000000000000000, 64'h0000000000000001, 64'h40CFFFFFFFFFFFFF
  };

  initial begin
    int lat;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sign", sign, 0);
    chk("rst_integer", integer_part, 0);
    chk("rst_fraction", fraction_part, 0);
    chk("rst_type", output_type, 0);

    send(64'h3FF8000000000000);
    wait_valid(lat);
    chk("latency", lat, 4);
    drain();

    foreach (directed[i]) send(directed[i]);
    drain();

    // Backpressure in HOLD: outputs of 1.5 must sit still, no new accept.
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    send(64'h3FF8000000000000);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_integer", integer_part, 1);
      chk("hold_fraction", fraction_part, 8);
      chk("hold_type", output_type, 0);
    end
    ready_force = 1'b1;
    drain();

    // Reset while the operand is in SHIFT: it is discarded.
    send(64'hC006000000000000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sign", sign, 0);
    chk("midrst_integer", integer_part, 0);
    chk("midrst_fraction", fraction_part, 0);
    chk("midrst_type", output_type, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    send(64'h4006000000000000);
    drain();

    bp_en = 1'b1;
    repeat (300) send(rand_dbl());
    bp_en = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
